// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light sequencer: state encoding,
// lamp bit positions and the lamp pattern shown in each state.
package tlc_pkg;

  typedef enum logic [2:0] {
    StMainGrn = 3'd0,
    StMainYel = 3'd1,
    StRedA    = 3'd2,
    StSideGrn = 3'd3,
    StSideYel = 3'd4,
    StWalk    = 3'd5,
    StRedB    = 3'd6
  } state_e;

  localparam int unsigned RM = 6;
  localparam int unsigned YM = 5;
  localparam int unsigned GM = 4;
  localparam int unsigned RS = 3;
  localparam int unsigned YS = 2;
  localparam int unsigned GS = 1;
  localparam int unsigned W  = 0;

  localparam logic [6:0] LampMainGrn = 7'b0011000;
  localparam logic [6:0] LampMainYel = 7'b0101000;
  localparam logic [6:0] LampRedA    = 7'b1001000;
  localparam logic [6:0] LampSideGrn = 7'b1000010;
  localparam logic [6:0] LampSideYel = 7'b1000100;
  localparam logic [6:0] LampWalk    = 7'b1001001;
  localparam logic [6:0] LampRedB    = 7'b1001000;

  function automatic logic [6:0] lamp_pattern(state_e s);
    logic [6:0] p;
    unique case (s)
      StMainGrn: p = LampMainGrn;
      StMainYel: p = LampMainYel;
      StRedA:    p = LampRedA;
      StSideGrn: p = LampSideGrn;
      StSideYel: p = LampSideYel;
      StWalk:    p = LampWalk;
      default:   p = LampRedB;
    endcase
    return p;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Lamp-side interface of the sequencer: lamp vector, debug phase and tick strobe.
// The sequencer drives it (master); the lamp-driver block listens (slave).
interface light_sequencer_if;
  logic [6:0] light_signals;
  logic [2:0] phase;
  logic       tick;

  modport master (output light_signals, phase, tick);
  modport slave  (input  light_signals, phase, tick);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic sys_reset,
  output logic tick
);
  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] count_q, count_d;

  assign tick = (count_q == CntW'(TICK_DIV - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Main/side road traffic-light controller with pedestrian walk phase.
// Lamps and phase are registered from the next state so they switch with the state.
module light_sequencer
  import tlc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned T_MAIN_MIN = 20,
  parameter int unsigned T_MAIN_YEL = 3,
  parameter int unsigned T_ALLRED   = 1,
  parameter int unsigned T_SIDE_GRN = 10,
  parameter int unsigned T_SIDE_YEL = 3,
  parameter int unsigned T_WALK     = 6
) (
  input  logic              clk,
  input  logic              sys_reset,
  input  logic              side_sensor,
  input  logic              walk_req,
  light_sequencer_if.master lamps
);
  localparam int unsigned TMax = max_u(max_u(max_u(T_MAIN_MIN, T_MAIN_YEL), max_u(T_ALLRED,
                                 T_SIDE_GRN)), max_u(T_SIDE_YEL, T_WALK));
  localparam int unsigned DwellW = (TMax > 1) ? $clog2(TMax) : 1;

  state_e            state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        side_sync_q, walk_sync_q;
  logic              side_pending_q, side_pending_d;
  logic              walk_pending_q, walk_pending_d;
  logic [6:0]        lamp_q, lamp_d;
  logic              tick;
  logic              dwell_last;
  logic              side_clr, walk_clr;
  int unsigned       t_cur;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .sys_reset(sys_reset),
    .tick     (tick)
  );

  // State register, synchronizers, counters and lamp outputs
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q        <= StRedB;
      dwell_q        <= '0;
      side_sync_q    <= '0;
      walk_sync_q    <= '0;
      side_pending_q <= 1'b0;
      walk_pending_q <= 1'b0;
      lamp_q         <= LampRedB;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      side_sync_q    <= {side_sync_q[0], side_sensor};
      walk_sync_q    <= {walk_sync_q[0], walk_req};
      side_pending_q <= side_pending_d;
      walk_pending_q <= walk_pending_d;
      lamp_q         <= lamp_d;
    end
  end

  always_comb begin
    t_cur = T_ALLRED;
    unique case (state_q)
      StMainGrn: t_cur = T_MAIN_MIN;
      StMainYel: t_cur = T_MAIN_YEL;
      StSideGrn: t_cur = T_SIDE_GRN;
      StSideYel: t_cur = T_SIDE_YEL;
      StWalk:    t_cur = T_WALK;
      default:   t_cur = T_ALLRED;
    endcase
  end

  // Greater-or-equal lets main green keep re-evaluating once its dwell saturates.
  assign dwell_last = tick && ((32'(dwell_q) + 32'd1) >= t_cur);

  // Next-state, dwell and request bookkeeping
  always_comb begin
    state_d = state_q;
    if (dwell_last) begin
      unique case (state_q)
        StMainGrn: if (side_pending_q || walk_pending_q) state_d = StMainYel;
        StMainYel: state_d = StRedA;
        StRedA:    state_d = walk_pending_q ? StWalk : StSideGrn;
        StSideGrn: state_d = StSideYel;
        StSideYel: state_d = StRedB;
        StWalk:    state_d = StRedB;
        default:   state_d = StMainGrn;
      endcase
    end

    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (tick && !dwell_last) begin
      dwell_d = dwell_q + DwellW'(1);
    end else begin
      dwell_d = dwell_q;
    end

    side_clr       = (state_d == StSideGrn) && (state_q != StSideGrn);
    walk_clr       = (state_d == StWalk) && (state_q != StWalk);
    side_pending_d = (side_pending_q | side_sync_q[1]) & ~side_clr;
    walk_pending_d = (walk_pending_q | walk_sync_q[1]) & ~walk_clr;
  end

  // Output decode from the next state
  always_comb begin
    lamp_d = lamp_pattern(state_d);
  end

  assign lamps.light_signals = lamp_q;
  assign lamps.phase         = state_q;
  assign lamps.tick          = tick;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed and random checks for light_sequencer with TICK_DIV=4 and default dwell times.
module tb_light_sequencer;

  localparam logic [6:0] LMG = 7'b0011000;
  localparam logic [6:0] LMY = 7'b0101000;
  localparam logic [6:0] LRA = 7'b1001000;
  localparam logic [6:0] LSG = 7'b1000010;
  localparam logic [6:0] LSY = 7'b1000100;
  localparam logic [6:0] LWK = 7'b1001001;
  localparam logic [6:0] LRB = 7'b1001000;

  localparam int ActCheck  = 0;
  localparam int ActWalk   = 1;
  localparam int ActSide   = 2;
  localparam int ActBoth   = 3;
  localparam int ActRebase = 4;

  typedef struct {
    int         t;
    int         act;
    logic [6:0] lamps;
    logic [2:0] phase;
    int         side_p;
    int         walk_p;
  } vec_t;

  logic clk = 1'b0;
  logic sys_reset = 1'b1;
  logic side_sensor = 1'b0;
  logic walk_req = 1'b0;

  light_sequencer_if lamps ();

  light_sequencer #(
    .TICK_DIV  (4),
    .T_MAIN_MIN(20),
    .T_MAIN_YEL(3),
    .T_ALLRED  (1),
    .T_SIDE_GRN(10),
    .T_SIDE_YEL(3),
    .T_WALK    (6)
  ) dut (
    .clk        (clk),
    .sys_reset  (sys_reset),
    .side_sensor(side_sensor),
    .walk_req   (walk_req),
    .lamps      (lamps.master)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cur_tick = 0;
  int   safety_viol = 0;
  int   phase_viol = 0;
  int   tick_viol = 0;
  int   since_tick = 0;
  bit   seen_tick = 1'b0;
  vec_t vecs[$];

  function automatic vec_t mk(int t, int act, logic [6:0] l, logic [2:0] p, int sp, int wp);
    vec_t r;
    r.t = t; r.act = act; r.lamps = l; r.phase = p; r.side_p = sp; r.walk_p = wp;
    return r;
  endfunction

  function automatic bit lamps_safe(logic [6:0] l);
    logic rm, ym, gm, rs, ys, gs, w;
    {rm, ym, gm, rs, ys, gs, w} = l;
    return (!(gm | ym) || rs) && (!(gs | ys | w) || rm) &&
           ($countones({rm, ym, gm}) == 1) && ($countones({rs, ys, gs}) == 1);
  endfunction

  function automatic logic [6:0] exp_lamps(logic [2:0] p);
    case (p)
      3'd0:    return LMG;
      3'd1:    return LMY;
      3'd2:    return LRA;
      3'd3:    return LSG;
      3'd4:    return LSY;
      3'd5:    return LWK;
      3'd6:    return LRB;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Call at a negedge; returns at the negedge just after the next tick edge.
  task automatic adv_tick();
    int n = 0;
    while (lamps.tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      n_checks++;
      $display("FAIL tick_timeout: no tick in %0d clk, expected within 4 (t=%0t)", n, $time);
    end
    @(negedge clk);
    cur_tick++;
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      while (cur_tick < vecs[i].t) adv_tick();
      case (vecs[i].act)
        ActWalk: begin
          walk_req = 1'b1; @(negedge clk); walk_req = 1'b0;
        end
        ActSide: begin
          side_sensor = 1'b1; repeat (3) @(negedge clk); side_sensor = 1'b0;
        end
        ActBoth: begin
          walk_req = 1'b1; side_sensor = 1'b1;
          @(negedge clk); walk_req = 1'b0;
          @(negedge clk); side_sensor = 1'b0;
        end
        ActRebase: cur_tick = 0;
        default: begin
          check($sformatf("lamps@%0d", vecs[i].t), 32'(lamps.light_signals), 32'(vecs[i].lamps));
          check($sformatf("phase@%0d", vecs[i].t), 32'(lamps.phase), 32'(vecs[i].phase));
          if (vecs[i].side_p >= 0)
            check($sformatf("side_pending@%0d", vecs[i].t), 32'(dut.side_pending_q),
                  32'(vecs[i].side_p));
          if (vecs[i].walk_p >= 0)
            check($sformatf("walk_pending@%0d", vecs[i].t), 32'(dut.walk_pending_q),
                  32'(vecs[i].walk_p));
        end
      endcase
    end
    vecs.delete();
  endtask

  // Continuous monitor: lamp safety, phase/lamp agreement, tick period.
  always @(negedge clk) begin
    if (sys_reset) begin
      seen_tick  = 1'b0;
      since_tick = 0;
    end else begin
      if (!lamps_safe(lamps.light_signals)) safety_viol++;
      if (exp_lamps(lamps.phase) !== lamps.light_signals) phase_viol++;
      since_tick++;
      if (lamps.tick === 1'b1) begin
        if (since_tick != (seen_tick ? 4 : 3)) tick_viol++;
        seen_tick  = 1'b1;
        since_tick = 0;
      end else if (since_tick > 4) begin
        tick_viol++;
      end
    end
  end

  initial begin
    // Reset and first main green, 4 clk after release
    repeat (3) @(negedge clk);
    check("rst_lamps", 32'(lamps.light_signals), 32'(LRB));
    check("rst_phase", 32'(lamps.phase), 32'd6);
    check("rst_tick", 32'(lamps.tick), 32'd0);
    #1 sys_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_tick3", 32'(lamps.tick), 32'd1);
    check("rel_lamps3", 32'(lamps.light_signals), 32'(LRB));
    @(negedge clk);
    check("rel_lamps4", 32'(lamps.light_signals), 32'(LMG));
    check("rel_phase4", 32'(lamps.phase), 32'd0);
    cur_tick = 0;

    // Side request at tick 5
    vecs.push_back(mk(5, ActSide, '0, '0, -1, -1));
    vecs.push_back(mk(19, ActCheck, LMG, 3'd0, 1, -1));
    vecs.push_back(mk(20, ActCheck, LMY, 3'd1, -1, -1));
    vecs.push_back(mk(22, ActCheck, LMY, 3'd1, -1, -1));
    vecs.push_back(mk(23, ActCheck, LRA, 3'd2, 1, -1));
    vecs.push_back(mk(24, ActCheck, LSG, 3'd3, 0, -1));
    vecs.push_back(mk(33, ActCheck, LSG, 3'd3, -1, -1));
    vecs.push_back(mk(34, ActCheck, LSY, 3'd4, -1, -1));
    vecs.push_back(mk(36, ActCheck, LSY, 3'd4, -1, -1));
    vecs.push_back(mk(37, ActCheck, LRB, 3'd6, -1, -1));
    vecs.push_back(mk(38, ActCheck, LMG, 3'd0, 0, -1));
    vecs.push_back(mk(38, ActRebase, '0, '0, -1, -1));
    // Walk and side together: walk first, side after the next main green
    vecs.push_back(mk(3, ActBoth, '0, '0, -1, -1));
    vecs.push_back(mk(19, ActCheck, LMG, 3'd0, 1, 1));
    vecs.push_back(mk(20, ActCheck, LMY, 3'd1, -1, -1));
    vecs.push_back(mk(23, ActCheck, LRA, 3'd2, -1, -1));
    vecs.push_back(mk(24, ActCheck, LWK, 3'd5, 1, 0));
    vecs.push_back(mk(29, ActCheck, LWK, 3'd5, -1, -1));
    vecs.push_back(mk(30, ActCheck, LRB, 3'd6, 1, -1));
    vecs.push_back(mk(31, ActCheck, LMG, 3'd0, 1, 0));
    vecs.push_back(mk(50, ActCheck, LMG, 3'd0, -1, -1));
    vecs.push_back(mk(51, ActCheck, LMY, 3'd1, -1, -1));
    vecs.push_back(mk(54, ActCheck, LRA, 3'd2, -1, -1));
    vecs.push_back(mk(55, ActCheck, LSG, 3'd3, 0, 0));
    vecs.push_back(mk(65, ActCheck, LSY, 3'd4, -1, -1));
    vecs.push_back(mk(68, ActCheck, LRB, 3'd6, -1, -1));
    vecs.push_back(mk(69, ActCheck, LMG, 3'd0, -1, -1));
    vecs.push_back(mk(69, ActRebase, '0, '0, -1, -1));
    // Walk pressed again during walk: one walk now, re-served next cycle
    vecs.push_back(mk(2, ActWalk, '0, '0, -1, -1));
    vecs.push_back(mk(24, ActCheck, LWK, 3'd5, -1, 0));
    vecs.push_back(mk(25, ActWalk, '0, '0, -1, -1));
    vecs.push_back(mk(27, ActWalk, '0, '0, -1, -1));
    vecs.push_back(mk(29, ActCheck, LWK, 3'd5, -1, 1));
    vecs.push_back(mk(30, ActCheck, LRB, 3'd6, -1, 1));
    vecs.push_back(mk(31, ActCheck, LMG, 3'd0, -1, 1));
    vecs.push_back(mk(50, ActCheck, LMG, 3'd0, -1, -1));
    vecs.push_back(mk(51, ActCheck, LMY, 3'd1, -1, -1));
    vecs.push_back(mk(54, ActCheck, LRA, 3'd2, -1, -1));
    vecs.push_back(mk(55, ActCheck, LWK, 3'd5, -1, 0));
    vecs.push_back(mk(60, ActCheck, LWK, 3'd5, -1, -1));
    vecs.push_back(mk(61, ActCheck, LRB, 3'd6, -1, -1));
    vecs.push_back(mk(62, ActCheck, LMG, 3'd0, 0, 0));
    run_vecs();

    // Idle main green holds indefinitely
    for (int i = 1; i <= 200; i++) begin
      adv_tick();
      check($sformatf("idle@%0d", i), {22'd0, lamps.phase, lamps.light_signals},
            {22'd0, 3'd0, LMG});
    end

    // After saturation a request exits main green on the very next tick
    walk_req = 1'b1; @(negedge clk); walk_req = 1'b0;
    adv_tick();
    check("sat_exit", 32'(lamps.phase), 32'd1);
    repeat (3) adv_tick();
    check("sat_reda", 32'(lamps.phase), 32'd2);
    adv_tick();
    check("sat_walk", 32'(lamps.light_signals), 32'(LWK));
    repeat (2) adv_tick();
    @(negedge clk);

    // Asynchronous reset in the middle of walk
    #2 sys_reset = 1'b1;
    #1;
    check("midrst_lamps", 32'(lamps.light_signals), 32'(LRB));
    check("midrst_phase", 32'(lamps.phase), 32'd6);
    check("midrst_tick", 32'(lamps.tick), 32'd0);
    @(negedge clk);
    #1 sys_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_red_hold", 32'(lamps.light_signals), 32'(LRB));
    @(negedge clk);
    check("midrst_main", 32'(lamps.light_signals), 32'(LMG));
    cur_tick = 0;

    // Random request traffic under the monitor
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) side_sensor = ~side_sensor;
      walk_req = ($urandom_range(0, 199) == 0);
    end
    walk_req = 1'b0;
    side_sensor = 1'b0;
    @(negedge clk);

    check("safety_violations", 32'(safety_viol), 32'd0);
    check("phase_lamp_mismatches", 32'(phase_viol), 32'd0);
    check("tick_period_violations", 32'(tick_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
Traffic-light controller FSM for a main/side road intersection with a pedestrian crossing. It produces the 7-bit `light_signals` lamp vector that the lamp-driver block fans out to the individual lamps. It is the source end of that interface.
- Dwell times are counted in ticks from an internal prescaler.
- Side-road car detection and pedestrian requests are latched and served in the next eligible phase.

Parameters:
- TICK_DIV, 50000000, clk cycles per dwell tick (1 s at 50 MHz); minimum 2.
- T_MAIN_MIN, 20, minimum main-green ticks before any request is served.
- T_MAIN_YEL, 3, main-yellow ticks.
- T_ALLRED, 1, all-red clearance ticks.
- T_SIDE_GRN, 10, side-green ticks.
- T_SIDE_YEL, 3, side-yellow ticks.
- T_WALK, 6, pedestrian-walk ticks.
- All T_* parameters must be >= 1.

Ports:
- clk  in  1  system clock
- sys_reset  in  1  reset; asynchronous, active-high
- side_sensor  in  1  side-road vehicle present; asynchronous level input
- walk_req  in  1  pedestrian button; asynchronous, any pulse of 1 clk or longer
- light_signals  out  7  lamp vector: [6]Rm [5]Ym [4]Gm [3]Rs [2]Ys [1]Gs [0]W
- phase  out  3  current state encoding, for debug
- tick  out  1  one-cycle prescaler strobe

Behaviour:
- Input sync: side_sensor and walk_req each pass through a 2-flop synchronizer. Synchronizer flops reset to 0.
- Prescaler: free-running counter 0..TICK_DIV-1. `tick`=1 in the cycle where count==TICK_DIV-1, then the counter wraps to 0.
- Dwell counter:
  - Cleared on every state change.
  - Increments on each tick.
  - The state's exit condition is evaluated on the tick where dwell+1 == T_state.
  - Width is clog2 of the largest T.
- States and lamp patterns:
  - MAIN_GRN=0, 7'b0011000
  - MAIN_YEL=1, 7'b0101000
  - RED_A=2, 7'b1001000
  - SIDE_GRN=3, 7'b1000010
  - SIDE_YEL=4, 7'b1000100
  - WALK=5, 7'b1001001
  - RED_B=6, 7'b1001000
- Transitions:
  - MAIN_GRN -> MAIN_YEL: on the first tick at or after T_MAIN_MIN elapsed with side_pending|walk_pending=1. Otherwise hold forever; the dwell counter saturates at T_MAIN_MIN-1.
  - MAIN_YEL -> RED_A after T_MAIN_YEL.
  - RED_A -> WALK if walk_pending, else SIDE_GRN. Walk has priority.
  - SIDE_GRN -> SIDE_YEL after T_SIDE_GRN.
  - SIDE_YEL -> RED_B after T_SIDE_YEL.
  - WALK -> RED_B after T_WALK.
  - RED_B -> MAIN_GRN after T_ALLRED.
- Requests:
  - side_pending is set by synchronized side_sensor==1 and cleared on the entry edge into SIDE_GRN.
  - walk_pending is set by synchronized walk_req==1 and cleared on the entry edge into WALK.
  - If set and clear occur in the same cycle, clear wins.
  - A request not served this cycle (e.g. side while walk is served) remains pending for the next main-green exit.
- Output timing:
  - light_signals and phase are registered, decoded from next_state.
  - They change on the same edge as the state register, with zero extra latency.
  - They are glitch-free.
- Reset:
  - On sys_reset=1, immediately and asynchronously: state=RED_B, light_signals=7'b1001000, phase=6, tick=0, all counters and pending flags 0.
  - After release, RED_B dwells T_ALLRED ticks, then enters MAIN_GRN.
  - Reset mid-phase, including green or walk, forces all-red immediately.
- Safety invariant, never violated: Gm|Ym is asserted only while Rs=1. Gs|Ys|W is asserted only while Rm=1. Exactly one of Rm/Ym/Gm and exactly one of Rs/Ys/Gs is set.

Decomposition:
- Package tlc_pkg holds:
  - the state enum/localparams (3-bit)
  - lamp bit-index constants RM..W
  - the seven 7-bit lamp pattern constants
- Sub-module tick_prescaler(clk, sys_reset, tick), parameterized by TICK_DIV.
- Synchronizers, pending flags, dwell counter and FSM stay in light_sequencer.

Test Plan (TICK_DIV=4, default T_*):
- Reset asserted mid-cycle -> light_signals=7'b1001000 and phase=6 in the same cycle without a clock edge. Release -> MAIN_GRN 7'b0011000 at the 1st tick, 4 clk later.
- No requests for 200 ticks -> light_signals stays 7'b0011000 and phase=0 throughout.
- side_sensor=1 for 3 clk at tick 5 of MAIN_GRN -> sequence:
  - MAIN_YEL at tick 20
  - RED_A at 23
  - SIDE_GRN 7'b1000010 at 24
  - SIDE_YEL at 34
  - RED_B at 37
  - MAIN_GRN at 38
  - side_pending=0 after SIDE_GRN entry.
- walk_req and side_sensor both pulsed during MAIN_GRN:
  - RED_A goes to WALK 7'b1001001 for 6 ticks, then RED_B, then MAIN_GRN.
  - side_pending stays 1.
  - SIDE_GRN is served after the next 20-tick main green.
- walk_req pulsed repeatedly during WALK -> one WALK per cycle; the request re-latches after the entry edge and is served at the next MAIN_GRN exit.
- Assertion monitor over a 10k-cycle random-request run -> safety invariant holds every cycle, and tick occurs exactly every 4 clk.
